// File: rtl/cgra_pe_tile.sv
// CGRA processing tile: register file, ALU and NDIR valid/ready neighbour channels.
// Optional single-cycle multiplier for ALU func 2 is enabled by defining CGRA_PE_MUL_EN.
module cgra_pe_tile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int NDIR   = 8,
  localparam int RA      = $clog2(NREGS),
  localparam int INSTR_W = 3 + 3*RA + 3 + 4 + DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_W-1:0]     instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic [NDIR*DATA_W-1:0] send_data,
  output logic [NDIR-1:0]        send_valid,
  input  logic [NDIR-1:0]        send_ready,
  input  logic [NDIR*DATA_W-1:0] recv_data,
  input  logic [NDIR-1:0]        recv_valid,
  output logic [NDIR-1:0]        recv_ready,
  output logic [DATA_W-1:0]      final_output,
  output logic                   out_valid
);

  localparam int SH = $clog2(DATA_W);

  localparam logic [2:0] OP_ALU   = 3'b000;
  localparam logic [2:0] OP_SEND  = 3'b001;
  localparam logic [2:0] OP_OUT   = 3'b010;
  localparam logic [2:0] OP_RECV  = 3'b100;
  localparam logic [2:0] OP_LOADI = 3'b110;

  typedef enum logic [1:0] {IDLE, WAIT_SEND, WAIT_RECV} state_t;
  state_t state;

  logic [DATA_W-1:0] rf [NREGS];
  logic [RA-1:0]     pend_rd;

  logic [2:0]        opcode;
  logic [RA-1:0]     rd, rs1, rs2;
  logic [2:0]        dir;
  logic [3:0]        func;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rs1_val, rs2_val, alu_res, recv_sel;
  logic [SH-1:0]     shamt;
  logic [NDIR-1:0]   dir_oh;
  logic              dir_ok, accept;

  assign opcode  = instr[2:0];
  assign rd      = instr[3 +: RA];
  assign rs1     = instr[3+RA +: RA];
  assign rs2     = instr[3+2*RA +: RA];
  assign dir     = instr[3+3*RA +: 3];
  assign func    = instr[6+3*RA +: 4];
  assign imm     = instr[10+3*RA +: DATA_W];
  assign rs1_val = rf[rs1];
  assign rs2_val = rf[rs2];
  assign shamt   = rs2_val[SH-1:0];

  // Valid/ready: a transfer occurs on a rising clk edge where both valid and ready are high.
  assign instr_ready = (state == IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;

  // Direction codes at or beyond NDIR decode to an empty one-hot and act as NOP.
  always_comb begin
    dir_oh = '0;
    dir_ok = 1'b0;
    for (int d = 0; d < NDIR; d++) begin
      if (dir == 3'(d)) begin
        dir_oh[d] = 1'b1;
        dir_ok    = 1'b1;
      end
    end
  end

  // recv_ready is one-hot while waiting, so it doubles as the pending channel select.
  always_comb begin
    recv_sel = '0;
    for (int d = 0; d < NDIR; d++) begin
      if (recv_ready[d]) recv_sel = recv_data[d*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    alu_res = '0;
    case (func)
      4'h0: alu_res = rs1_val + rs2_val;
      4'h1: alu_res = rs1_val - rs2_val;
`ifdef CGRA_PE_MUL_EN
      4'h2: alu_res = rs1_val * rs2_val;
`else
      4'h2: alu_res = '0;
`endif
      4'h3: alu_res = rs1_val << shamt;
      4'h4: alu_res = rs1_val >> shamt;
      4'h5: alu_res = {{(DATA_W-1){1'b0}}, rs1_val < rs2_val};
      4'h6: alu_res = {{(DATA_W-1){1'b0}}, rs1_val > rs2_val};
      4'h7: alu_res = {{(DATA_W-1){1'b0}}, rs1_val == rs2_val};
      4'h8: alu_res = rs1_val | rs2_val;
      4'h9: alu_res = rs1_val & rs2_val;
      4'hA: alu_res = rs1_val ^ rs2_val;
      4'hB: alu_res = $signed(rs1_val) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pend_rd      <= '0;
      send_data    <= '0;
      send_valid   <= '0;
      recv_ready   <= '0;
      final_output <= '0;
      out_valid    <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (opcode)
              OP_ALU:   rf[rd] <= alu_res;
              OP_SEND: begin
                if (dir_ok) begin
                  for (int d = 0; d < NDIR; d++) begin
                    if (dir_oh[d]) send_data[d*DATA_W +: DATA_W] <= rs1_val;
                  end
                  send_valid <= dir_oh;
                  state      <= WAIT_SEND;
                end
              end
              OP_OUT: begin
                final_output <= rs1_val;
                out_valid    <= 1'b1;
              end
              OP_RECV: begin
                if (dir_ok) begin
                  recv_ready <= dir_oh;
                  pend_rd    <= rd;
                  state      <= WAIT_RECV;
                end
              end
              OP_LOADI: rf[rd] <= imm;
              default: ;
            endcase
          end
        end
        WAIT_SEND: begin
          if (|(send_valid & send_ready)) begin
            send_valid <= '0;
            state      <= IDLE;
          end
        end
        WAIT_RECV: begin
          if (|(recv_valid & recv_ready)) begin
            rf[pend_rd] <= recv_sel;
            recv_ready  <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_pe_tile.sv
// Directed and randomized bench for cgra_pe_tile against a behavioural register/ALU model.
module tb_cgra_pe_tile;
  localparam int DATA_W = 32;
  localparam int NREGS = 8;
  localparam int NDIR = 8;
  localparam int INSTR_W = 3 + 3*3 + 3 + 4 + DATA_W;

  localparam logic [2:0] OP_ALU = 3'b000, OP_SEND = 3'b001, OP_OUT = 3'b010;
  localparam logic [2:0] OP_RECV = 3'b100, OP_LOADI = 3'b110, OP_NOP = 3'b111;

  logic clk = 1'b0;
  logic rst;
  logic [INSTR_W-1:0] instr;
  logic instr_valid, instr_ready;
  logic [NDIR*DATA_W-1:0] send_data, recv_data;
  logic [NDIR-1:0] send_valid, send_ready, recv_valid, recv_ready;
  logic [DATA_W-1:0] final_output;
  logic out_valid;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic [DATA_W-1:0] model_rf [NREGS];
  logic [DATA_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  cgra_pe_tile dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .send_data(send_data), .send_valid(send_valid),
    .send_ready(send_ready), .recv_data(recv_data), .recv_valid(recv_valid),
    .recv_ready(recv_ready), .final_output(final_output), .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input int rd, input int rs1,
                                            input int rs2, input int dir, input int f,
                                            input logic [DATA_W-1:0] imm);
    return {imm, 4'(f), 3'(dir), 3'(rs2), 3'(rs1), 3'(rd), op};
  endfunction

  // reference ALU from the arithmetic definition of each function
  function automatic logic [DATA_W-1:0] alu_ref(input int f, input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    longint unsigned wa = {32'b0, a};
    longint unsigned wb = {32'b0, b};
    longint unsigned na = {32'b0, ~a};
    longint unsigned p2 = 1;
    int sh = int'(b % 32);
    repeat (sh) p2 = p2 * 2;
    case (f)
      0: return 32'(wa + wb);
      1: return 32'(wa + 64'h1_0000_0000 - wb);
`ifdef CGRA_PE_MUL_EN
      2: return 32'(wa * wb);
`else
      2: return 32'd0;
`endif
      3: return 32'(wa * p2);
      4: return 32'(wa / p2);
      5: return (wa < wb) ? 32'd1 : 32'd0;
      6: return (wa > wb) ? 32'd1 : 32'd0;
      7: return (wa == wb) ? 32'd1 : 32'd0;
      8: return a | b;
      9: return a & b;
      10: return a ^ b;
      11: return a[31] ? ~32'(na / p2) : 32'(wa / p2);
      default: return 32'd0;
    endcase
  endfunction

  // driver tasks
  task automatic issue(input logic [INSTR_W-1:0] ins);
    @(negedge clk);
    chk("instr_ready_idle", {31'b0, instr_ready}, 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic do_loadi(input int rd, input logic [DATA_W-1:0] val);
    issue(mk(OP_LOADI, rd, 0, 0, 0, 0, val));
    model_rf[rd] = val;
  endtask

  task automatic do_alu(input int f, input int rd, input int rs1, input int rs2);
    logic [DATA_W-1:0] r;
    r = alu_ref(f, model_rf[rs1], model_rf[rs2]);
    issue(mk(OP_ALU, rd, rs1, rs2, 0, f, $urandom));
    model_rf[rd] = r;
  endtask

  task automatic do_out(input string tag, input int rs, input logic [DATA_W-1:0] exp);
    exp_q.push_back(exp);
    issue(mk(OP_OUT, 0, rs, 0, 0, 0, 0));
    chk("out_valid_pulse", {31'b0, out_valid}, 32'd1);
    chk(tag, final_output, exp_q.pop_front());
    @(posedge clk);
    #1;
    chk("out_valid_drop", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic do_send(input int rs, input int dir, input int delay);
    logic [DATA_W-1:0] v;
    v = model_rf[rs];
    send_ready = '0;
    issue(mk(OP_SEND, 0, rs, 0, dir, 0, 0));
    chk("send_valid_set", 32'(send_valid), 32'(1) << dir);
    chk("send_instr_ready", {31'b0, instr_ready}, 32'd0);
    repeat (delay) begin
      @(posedge clk);
      #1;
      chk("send_valid_hold", 32'(send_valid), 32'(1) << dir);
      chk("send_busy", {31'b0, instr_ready}, 32'd0);
    end
    send_ready[dir] = 1'b1;
    @(posedge clk);
    #1;
    send_ready = '0;
    chk("send_valid_clr", 32'(send_valid), 32'd0);
    chk("send_done_ready", {31'b0, instr_ready}, 32'd1);
    chk("send_data_slice", send_data[dir*DATA_W +: DATA_W], v);
  endtask

  task automatic do_recv(input int rd, input int dir, input int delay,
                         input logic [DATA_W-1:0] val, input logic [NDIR-1:0] others);
    for (int d = 0; d < NDIR; d++) recv_data[d*DATA_W +: DATA_W] = $urandom;
    recv_data[dir*DATA_W +: DATA_W] = val;
    recv_valid = others;
    recv_valid[dir] = (delay == 0);
    issue(mk(OP_RECV, rd, 0, 0, dir, 0, 0));
    chk("recv_ready_set", 32'(recv_ready), 32'(1) << dir);
    repeat (delay) begin
      @(posedge clk);
      #1;
      chk("recv_ready_hold", 32'(recv_ready), 32'(1) << dir);
    end
    recv_valid[dir] = 1'b1;
    @(posedge clk);
    #1;
    recv_valid = '0;
    chk("recv_ready_clr", 32'(recv_ready), 32'd0);
    model_rf[rd] = val;
  endtask

  initial begin
    int f, rd, rs1, rs2, dir;
    logic [DATA_W-1:0] mul_exp;
    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    send_ready = '0;
    recv_valid = '0;
    recv_data = '0;
    for (int i = 0; i < NREGS; i++) model_rf[i] = '0;

    // reset state
    #2;
    chk("rst_instr_ready", {31'b0, instr_ready}, 32'd0);
    chk("rst_send_valid", 32'(send_valid), 32'd0);
    chk("rst_recv_ready", 32'(recv_ready), 32'd0);
    chk("rst_final_output", final_output, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_send_data", {31'b0, |send_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_instr_ready", {31'b0, instr_ready}, 32'd1);

    // basic dataflow
    do_loadi(1, 32'd5);
    do_loadi(2, 32'd7);
    do_alu(0, 3, 1, 2);
    do_out("add_5_7", 3, 32'd12);

    do_send(3, 2, 4);
    do_recv(4, 7, 0, 32'hDEADBEEF, 8'h01);
    do_out("recv_dir7", 4, 32'hDEADBEEF);

    // directed ALU corners
    do_loadi(1, 32'd3);
    do_loadi(2, 32'd5);
    do_alu(1, 3, 1, 2);
    do_out("sub_wrap", 3, 32'hFFFFFFFE);
    do_loadi(5, 32'h80000000);
    do_loadi(6, 32'd4);
    do_alu(11, 7, 5, 6);
    do_out("sra_neg", 7, 32'hF8000000);
    do_loadi(6, 32'd33);
    do_alu(3, 7, 1, 6);
    do_out("sll_33", 7, 32'd6);
    do_alu(13, 7, 1, 2);
    do_out("func_d", 7, 32'd0);
    do_alu(0, 1, 1, 1);
    do_out("rd_eq_rs1", 1, 32'd6);
    issue(mk(OP_NOP, 1, 2, 3, 0, 0, 32'h55));
    do_out("nop_no_write", 1, 32'd6);
    do_loadi(1, 32'h10000);
    do_loadi(2, 32'h10000);
    do_alu(2, 3, 1, 2);
    do_out("mul_overflow", 3, 32'd0);
    do_loadi(1, 32'd6);
    do_loadi(2, 32'd7);
    do_alu(2, 3, 1, 2);
`ifdef CGRA_PE_MUL_EN
    mul_exp = 32'd42;
`else
    mul_exp = 32'd0;
`endif
    do_out("mul_6_7", 3, mul_exp);

    // randomized ALU traffic against the model
    for (int i = 0; i < NREGS; i++) do_loadi(i, $urandom);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) do_loadi($urandom_range(0, NREGS-1), $urandom);
      f = $urandom_range(0, 15);
      rd = $urandom_range(0, NREGS-1);
      rs1 = $urandom_range(0, NREGS-1);
      rs2 = $urandom_range(0, NREGS-1);
      do_alu(f, rd, rs1, rs2);
      do_out("rand_alu", rd, model_rf[rd]);
    end

    // randomized neighbour traffic
    for (int n = 0; n < 6; n++) begin
      dir = $urandom_range(0, NDIR-1);
      do_send($urandom_range(0, NREGS-1), dir, $urandom_range(0, 3));
      rd = $urandom_range(0, NREGS-1);
      do_recv(rd, $urandom_range(0, NDIR-1), $urandom_range(0, 3), $urandom, 8'($urandom));
      do_out("rand_recv", rd, model_rf[rd]);
    end

    // asynchronous reset in the middle of WAIT_SEND
    do_loadi(3, 32'd12);
    do_send(3, 2, 0);
    issue(mk(OP_SEND, 0, 3, 0, 5, 0, 0));
    chk("mid_send_valid", 32'(send_valid), 32'h20);
    #2;
    rst = 1'b1;
    #1;
    chk("async_send_valid", 32'(send_valid), 32'd0);
    chk("async_instr_ready", {31'b0, instr_ready}, 32'd0);
    chk("async_send_data", send_data[2*DATA_W +: DATA_W], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) model_rf[i] = '0;
    #1;
    chk("post_rst_ready", {31'b0, instr_ready}, 32'd1);
    do_out("post_rst_r3", 3, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
